// File: rtl/image_reconstructor_1.sv
// Image_Reconstructor_1: streams a 6x8 gray image rebuilt from a 1-bit
// halftone snapshot. Each gray pixel is the 3x3 neighbourhood ones-count
// (edges replicated) scaled to 0..255, handed out with a valid/ready handshake.
module image_reconstructor_1 (
    input  logic       clk,
    input  logic       reset,
    input  logic       Go,
    input  logic       Ready,
    input  logic [1:8] HTPV_Row_1,
    input  logic [1:8] HTPV_Row_2,
    input  logic [1:8] HTPV_Row_3,
    input  logic [1:8] HTPV_Row_4,
    input  logic [1:8] HTPV_Row_5,
    input  logic [1:8] HTPV_Row_6,
    output logic [7:0] pixel_out,
    output logic [5:0] pixel_addr,
    output logic       pixel_valid,
    output logic       Done
);

    localparam int NUM_ROWS = 6;
    localparam int NUM_COLS = 8;
    localparam logic [5:0] LAST_ADDR = 6'd47;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

    // Presented pixel: gray value plus its linear address.
    typedef struct packed {
        logic [7:0] gray;
        logic [5:0] addr;
    } pix_t;

    // Image storage: img[r][c], r = row-1, c = col-1.
    typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] img_t;

    state_t     state_q, state_d;
    img_t       img_q, img_d, img_in, src_img;
    pix_t       pix_q, pix_d;
    logic [5:0] src_addr;
    logic [7:0] src_gray;
    logic [1:8] row_in [NUM_ROWS];
    logic       load, hs, last;

    assign row_in[0] = HTPV_Row_1;
    assign row_in[1] = HTPV_Row_2;
    assign row_in[2] = HTPV_Row_3;
    assign row_in[3] = HTPV_Row_4;
    assign row_in[4] = HTPV_Row_5;
    assign row_in[5] = HTPV_Row_6;

    // Input rows are numbered from column 1 on the left; remap to 0-based.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            assign img_in[r][c] = row_in[r][c+1];
        end
    end

    // round(n*255/9) for n = 0..9.
    function automatic logic [7:0] gray_lut(input logic [3:0] n);
        case (n)
            4'd0:    return 8'd0;
            4'd1:    return 8'd28;
            4'd2:    return 8'd57;
            4'd3:    return 8'd85;
            4'd4:    return 8'd113;
            4'd5:    return 8'd142;
            4'd6:    return 8'd170;
            4'd7:    return 8'd198;
            4'd8:    return 8'd227;
            default: return 8'd255;
        endcase
    endfunction

    // Ones-count over the 3x3 window centred on addr, clamping to the edges.
    function automatic logic [7:0] window_gray(input img_t im, input logic [5:0] addr);
        logic [3:0] n;
        int         r, c, rr, cc;
        r = int'(addr[5:3]);
        c = int'(addr[2:0]);
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (rr < 0) rr = 0;
                else if (rr > NUM_ROWS-1) rr = NUM_ROWS-1;
                if (cc < 0) cc = 0;
                else if (cc > NUM_COLS-1) cc = NUM_COLS-1;
                n = n + 4'(im[rr[2:0]][cc[2:0]]);
            end
        end
        return gray_lut(n);
    endfunction

    // Go only starts a frame outside SEND; a handshake needs a presented pixel.
    assign load = Go && (state_q != ST_SEND);
    assign hs   = (state_q == ST_SEND) && Ready;
    assign last = (pix_q.addr == LAST_ADDR);

    // Single gray evaluator: on a start it reads the live rows at addr 0,
    // otherwise the stored snapshot at the following address.
    assign src_img  = load ? img_in : img_q;
    assign src_addr = load ? 6'd0 : pix_q.addr + 6'd1;
    assign src_gray = window_gray(src_img, src_addr);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (Go)           state_d = ST_SEND;
            ST_SEND:          if (Ready && last) state_d = ST_DONE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: snapshot on start, advance on handshake,
    // hold otherwise (stalls and the final handshake leave the pixel alone).
    always_comb begin
        img_d = img_q;
        pix_d = pix_q;
        if (load) begin
            img_d      = img_in;
            pix_d.addr = 6'd0;
            pix_d.gray = src_gray;
        end else if (hs && !last) begin
            pix_d.addr = src_addr;
            pix_d.gray = src_gray;
        end
    end

    // Snapshot and presented-pixel registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_q <= '0;
            pix_q <= '0;
        end else begin
            img_q <= img_d;
            pix_q <= pix_d;
        end
    end

    assign pixel_out   = pix_q.gray;
    assign pixel_addr  = pix_q.addr;
    assign pixel_valid = (state_q == ST_SEND);
    assign Done        = (state_q == ST_DONE);

endmodule
